// File: rtl/qam_symbol_mapper.sv
// Serial bit to QAM symbol mapper: Gray-maps interleaved Q/I bits to signed I/Q amplitudes.
// Outputs register one cycle after the final bit is captured. No backpressure: every strobe edge is consumed.
module qam_symbol_mapper #(
   parameter int MODE      = 0,
   parameter int AMP_W     = 8,
   parameter int LVL_OUTER = 96,
   parameter int LVL_INNER = 32,
   parameter int TIMEOUT   = 2048
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             bit_in,
   input  logic             bit_strobe,
   output logic [AMP_W-1:0] sym_i,
   output logic [AMP_W-1:0] sym_q,
   output logic             sym_valid,
   output logic [15:0]      sym_count,
   output logic             underrun
);

   localparam int NBITS = (MODE != 0) ? 4 : 2;
   localparam int TW    = $clog2(TIMEOUT) + 1;
   localparam logic [AMP_W-1:0] POS_OUT = AMP_W'(LVL_OUTER);
   localparam logic [AMP_W-1:0] NEG_OUT = AMP_W'(-LVL_OUTER);
   localparam logic [AMP_W-1:0] POS_IN  = AMP_W'(LVL_INNER);
   localparam logic [AMP_W-1:0] NEG_IN  = AMP_W'(-LVL_INNER);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_UNDERRUN} state_t;

   state_t           state, state_nxt;
   logic             strobe_d;
   logic             strobe_edge;
   logic             last_bit;
   logic             timeout_hit;
   logic             sym_done;
   logic [1:0]       bit_cnt;
   logic [3:0]       shreg;
   logic [TW-1:0]    timer;
   logic [AMP_W-1:0] q_amp;
   logic [AMP_W-1:0] i_amp;

   function automatic logic [AMP_W-1:0] gray16(input logic [1:0] b);
      case (b)
         2'b00:   return NEG_OUT;
         2'b01:   return NEG_IN;
         2'b11:   return POS_IN;
         default: return POS_OUT;
      endcase
   endfunction

   assign strobe_edge = bit_strobe & ~strobe_d;
   assign last_bit    = (bit_cnt == 2'(NBITS - 1));
   // A strobe edge on the terminal-count cycle takes priority over the timeout.
   assign timeout_hit = (state == S_COLLECT) && (bit_cnt != 2'd0) &&
                        (timer == TW'(TIMEOUT - 1)) && !strobe_edge;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_UNDERRUN: if (strobe_edge) state_nxt = S_COLLECT;
         S_COLLECT:          if (timeout_hit) state_nxt = S_UNDERRUN;
         default:            state_nxt = S_IDLE;
      endcase
   end

   // Shift order is Q1,I1,Q0,I0 (16-QAM) or Q,I (4-QAM), first bit in the MSB.
   always_comb begin
      if (MODE != 0) begin
         q_amp = gray16({shreg[3], shreg[1]});
         i_amp = gray16({shreg[2], shreg[0]});
      end else begin
         q_amp = shreg[1] ? POS_OUT : NEG_OUT;
         i_amp = shreg[0] ? POS_OUT : NEG_OUT;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= S_IDLE;
         strobe_d  <= 1'b1;
         bit_cnt   <= 2'd0;
         shreg     <= 4'd0;
         timer     <= '0;
         sym_done  <= 1'b0;
         sym_i     <= '0;
         sym_q     <= '0;
         sym_valid <= 1'b0;
         sym_count <= 16'd0;
         underrun  <= 1'b0;
      end else begin
         state     <= state_nxt;
         strobe_d  <= bit_strobe;
         sym_done  <= strobe_edge & last_bit;
         sym_valid <= 1'b0;

         if (strobe_edge) begin
            shreg   <= {shreg[2:0], bit_in};
            bit_cnt <= last_bit ? 2'd0 : bit_cnt + 2'd1;
            timer   <= '0;
         end else if (timeout_hit) begin
            bit_cnt <= 2'd0;
            timer   <= '0;
         end else if (bit_cnt != 2'd0) begin
            timer <= timer + TW'(1);
         end

         if (timeout_hit) begin
            sym_i    <= '0;
            sym_q    <= '0;
            underrun <= 1'b1;
         end else if (sym_done) begin
            sym_i     <= i_amp;
            sym_q     <= q_amp;
            sym_valid <= 1'b1;
            sym_count <= sym_count + 16'd1;
            underrun  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_qam_symbol_mapper.sv
// Directed bench for qam_symbol_mapper: a 16-QAM and a 4-QAM instance with independent stimulus.
module tb_qam_symbol_mapper;

   localparam int TIMEOUT = 2048;

   logic        clock = 1'b0;
   logic        reset;
   logic        bi16, st16, bi4, st4;
   logic [7:0]  i16, q16, i4, q4;
   logic        v16, v4, ur16, ur4;
   logic [15:0] c16, c4;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] cnt16 = 16'd0;
   logic [15:0] cnt4  = 16'd0;
   logic [7:0]  pq16 = 8'h00, pi16 = 8'h00, pq4 = 8'h00, pi4 = 8'h00;

   typedef struct {
      logic       mode;
      logic [3:0] bits;
      logic [7:0] exp_q;
      logic [7:0] exp_i;
   } vec_t;

   vec_t vecs[10];

   always #5 clock = ~clock;

   qam_symbol_mapper #(.MODE(1), .AMP_W(8), .LVL_OUTER(96), .LVL_INNER(32), .TIMEOUT(TIMEOUT)) dut16 (
      .clock(clock), .reset(reset), .bit_in(bi16), .bit_strobe(st16),
      .sym_i(i16), .sym_q(q16), .sym_valid(v16), .sym_count(c16), .underrun(ur16));

   qam_symbol_mapper #(.MODE(0), .AMP_W(8), .LVL_OUTER(96), .LVL_INNER(32), .TIMEOUT(TIMEOUT)) dut4 (
      .clock(clock), .reset(reset), .bit_in(bi4), .bit_strobe(st4),
      .sym_i(i4), .sym_q(q4), .sym_valid(v4), .sym_count(c4), .underrun(ur4));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic sel, input logic b);
      if (sel) begin bi16 = b; st16 = 1'b1; end
      else     begin bi4  = b; st4  = 1'b1; end
      tick();
      if (sel) st16 = 1'b0;
      else     st4  = 1'b0;
      tick();
   endtask

   task automatic send4(input logic [3:0] b);
      for (int k = 3; k >= 0; k--) send_bit(1'b1, b[k]);
   endtask

   task automatic check_sym16(input string name, input logic [7:0] eq, input logic [7:0] ei);
      cnt16 = cnt16 + 16'd1;
      check({name, "_valid"}, {15'd0, v16}, 16'd1);
      check({name, "_q"}, {8'd0, q16}, {8'd0, eq});
      check({name, "_i"}, {8'd0, i16}, {8'd0, ei});
      check({name, "_count"}, c16, cnt16);
      check({name, "_underrun"}, {15'd0, ur16}, 16'd0);
      pq16 = eq;
      pi16 = ei;
   endtask

   initial begin
      vecs[0] = '{1'b1, 4'b0111, 8'hE0, 8'h20};
      vecs[1] = '{1'b1, 4'b1000, 8'h60, 8'hA0};
      vecs[2] = '{1'b1, 4'b0001, 8'hA0, 8'hE0};
      vecs[3] = '{1'b1, 4'b1111, 8'h20, 8'h20};
      vecs[4] = '{1'b1, 4'b0010, 8'hE0, 8'hA0};
      vecs[5] = '{1'b1, 4'b1101, 8'h60, 8'h20};
      vecs[6] = '{1'b0, 4'b0010, 8'h60, 8'hA0};
      vecs[7] = '{1'b0, 4'b0001, 8'hA0, 8'h60};
      vecs[8] = '{1'b0, 4'b0011, 8'h60, 8'h60};
      vecs[9] = '{1'b0, 4'b0000, 8'hA0, 8'hA0};

      // Reset held with strobes high, then released with strobes still high.
      reset = 1'b0; bi16 = 1'b1; bi4 = 1'b1; st16 = 1'b1; st4 = 1'b1;
      repeat (3) tick();
      check("rst_i16", {8'd0, i16}, 16'd0);
      check("rst_q16", {8'd0, q16}, 16'd0);
      check("rst_valid16", {15'd0, v16}, 16'd0);
      check("rst_count16", c16, 16'd0);
      check("rst_underrun16", {15'd0, ur16}, 16'd0);
      check("rst_q4", {8'd0, q4}, 16'd0);
      reset = 1'b1;
      repeat (4) tick();
      check("rel_valid16", {15'd0, v16}, 16'd0);
      check("rel_count16", c16, 16'd0);
      check("rel_count4", c4, 16'd0);
      st16 = 1'b0; st4 = 1'b0;
      tick();

      for (int v = 0; v < 10; v++) begin
         automatic int n = vecs[v].mode ? 4 : 2;
         for (int k = 0; k < n; k++) begin
            send_bit(vecs[v].mode, vecs[v].bits[n-1-k]);
            if (k == 0) begin
               check($sformatf("v%0d_hold_q", v), {8'd0, vecs[v].mode ? q16 : q4},
                     {8'd0, vecs[v].mode ? pq16 : pq4});
               check($sformatf("v%0d_hold_i", v), {8'd0, vecs[v].mode ? i16 : i4},
                     {8'd0, vecs[v].mode ? pi16 : pi4});
               check($sformatf("v%0d_novalid", v), {15'd0, vecs[v].mode ? v16 : v4}, 16'd0);
            end
         end
         if (vecs[v].mode) cnt16 = cnt16 + 16'd1;
         else              cnt4  = cnt4 + 16'd1;
         check($sformatf("v%0d_valid", v), {15'd0, vecs[v].mode ? v16 : v4}, 16'd1);
         check($sformatf("v%0d_q", v), {8'd0, vecs[v].mode ? q16 : q4}, {8'd0, vecs[v].exp_q});
         check($sformatf("v%0d_i", v), {8'd0, vecs[v].mode ? i16 : i4}, {8'd0, vecs[v].exp_i});
         check($sformatf("v%0d_count", v), vecs[v].mode ? c16 : c4, vecs[v].mode ? cnt16 : cnt4);
         tick();
         check($sformatf("v%0d_pulse", v), {15'd0, vecs[v].mode ? v16 : v4}, 16'd0);
         if (vecs[v].mode) begin pq16 = vecs[v].exp_q; pi16 = vecs[v].exp_i; end
         else              begin pq4  = vecs[v].exp_q; pi4  = vecs[v].exp_i; end
      end

      // 4-QAM strobe held high for 10 cycles counts as one edge.
      bi4 = 1'b1; st4 = 1'b1;
      repeat (10) tick();
      st4 = 1'b0;
      tick();
      check("held_no_early", c4, cnt4);
      send_bit(1'b0, 1'b0);
      cnt4 = cnt4 + 16'd1;
      check("held_valid", {15'd0, v4}, 16'd1);
      check("held_q", {8'd0, q4}, 16'h0060);
      check("held_i", {8'd0, i4}, 16'h00A0);
      check("held_count", c4, cnt4);

      // Idle between symbols: no timeout, outputs hold.
      repeat (TIMEOUT + 10) tick();
      check("idle_underrun", {15'd0, ur16}, 16'd0);
      check("idle_hold_q", {8'd0, q16}, {8'd0, pq16});
      check("idle_hold_i", {8'd0, i16}, {8'd0, pi16});

      // Underrun after two bits of a 16-QAM symbol.
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      repeat (TIMEOUT - 2) tick();
      check("ur_not_early", {15'd0, ur16}, 16'd0);
      tick();
      check("ur_set", {15'd0, ur16}, 16'd1);
      check("ur_i_zero", {8'd0, i16}, 16'd0);
      check("ur_q_zero", {8'd0, q16}, 16'd0);
      repeat (5) tick();
      check("ur_held", {15'd0, ur16}, 16'd1);
      for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b1);
      check("ur_until_done", {15'd0, ur16}, 16'd1);
      check("ur_out_zero", {8'd0, q16}, 16'd0);
      send_bit(1'b1, 1'b1);
      check_sym16("ur_recover", 8'h20, 8'h20);
      tick();

      // Edge landing on the timeout terminal-count cycle wins.
      send_bit(1'b1, 1'b0);
      repeat (TIMEOUT - 2) tick();
      send_bit(1'b1, 1'b1);
      check("tie_no_underrun", {15'd0, ur16}, 16'd0);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      check_sym16("tie_sym", 8'hE0, 8'h60);
      tick();

      // Reset mid-symbol drops partial bits.
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b1);
      reset = 1'b0;
      tick();
      check("mid_rst_count", c16, 16'd0);
      check("mid_rst_i", {8'd0, i16}, 16'd0);
      check("mid_rst_q", {8'd0, q16}, 16'd0);
      reset = 1'b1;
      cnt16 = 16'd0; cnt4 = 16'd0;
      tick();
      send4(4'b0011);
      check_sym16("mid_rst_sym", 8'hE0, 8'hE0);
      tick();

      // Counter wrap.
      force dut16.sym_count = 16'hFFFE;
      tick();
      release dut16.sym_count;
      cnt16 = 16'hFFFE;
      send4(4'b1010);
      check_sym16("wrap_ffff", 8'h20, 8'hA0);
      tick();
      send4(4'b0101);
      check_sym16("wrap_zero", 8'hA0, 8'h20);
      tick();
      check("wrap_pulse", {15'd0, v16}, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
